// File: rtl/mp_regfile_sb.sv
// mp_regfile_sb
//
// Multi-ported register file with an attached scoreboard of pending
// destination registers.  Register 0 is hardwired to zero and is never
// pending.  Each write port both stores data and clears the pending bit of
// its target register.  Each issue port marks its destination register as
// pending.  A higher port index is a younger instruction.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN  - same-cycle write-to-read forwarding on every read port.
//                        Undefined by default: reads show stored state only.
//
// Parameters:
//   DATA_W  register width in bits
//   ADDR_W  address width, depth = 2**ADDR_W
//   NUM_RD  number of read ports
//   NUM_WR  number of write ports and of issue ports
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   wr_en     per-port write enable
//   wr_addr   packed write addresses, port p at [p*ADDR_W +: ADDR_W]
//   wr_data   packed write data, port p at [p*DATA_W +: DATA_W]
//   iss_en    per-port issue strobe, marks iss_addr pending
//   iss_addr  packed issue destination addresses
//   rd_addr   packed read addresses
//   rd_data   packed read data, combinational
//   rd_busy   per-read-port pending flag of the addressed register
//   busy_cnt  number of registers currently pending
module mp_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_WR-1:0]          iss_en,
    input  logic [NUM_WR*ADDR_W-1:0]   iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busyCnt_q;
    logic [ADDR_W:0]   busyCnt_d;

    // Next-state: ports are walked in ascending order so the youngest
    // (highest-index) write to an address is the one that sticks.  Issues
    // are applied after all write-side clears so a same-cycle issue wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                regs_d[wr_addr[p*ADDR_W +: ADDR_W]] = wr_data[p*DATA_W +: DATA_W];
                busy_d[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (iss_en[p]) begin
                busy_d[iss_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        // Anything aimed at register 0 is discarded here.
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        busyCnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busyCnt_d = busyCnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    // Storage, scoreboard and pending count all advance on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            busyCnt_q <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            busyCnt_q <= busyCnt_d;
        end
    end

    assign busy_cnt = busyCnt_q;

`ifdef REGFILE_BYPASS_EN
    logic [NUM_RD-1:0] wrHit;
    logic [NUM_RD-1:0] issHit;

    // Read path with forwarding.  A matching in-flight write supplies the
    // data and means the register is no longer pending, unless an issue in
    // the same cycle re-marks it.  Forwarding is gated by rst so nothing
    // leaks through while the file is held in reset.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        wrHit   = '0;
        issHit  = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (rd_addr[r*ADDR_W +: ADDR_W] != '0) begin
                rd_data[r*DATA_W +: DATA_W] = regs_q[rd_addr[r*ADDR_W +: ADDR_W]];
                rd_busy[r] = busy_q[rd_addr[r*ADDR_W +: ADDR_W]];
                for (int p = 0; p < NUM_WR; p++) begin
                    if (rst && wr_en[p] &&
                        (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W])) begin
                        rd_data[r*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
                        wrHit[r] = 1'b1;
                    end
                    if (rst && iss_en[p] &&
                        (iss_addr[p*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W])) begin
                        issHit[r] = 1'b1;
                    end
                end
                if (wrHit[r]) begin
                    rd_busy[r] = issHit[r];
                end
            end
        end
    end
`else
    // Read path without forwarding: stored state only, register 0 forced to 0.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (rd_addr[r*ADDR_W +: ADDR_W] != '0) begin
                rd_data[r*DATA_W +: DATA_W] = regs_q[rd_addr[r*ADDR_W +: ADDR_W]];
                rd_busy[r] = busy_q[rd_addr[r*ADDR_W +: ADDR_W]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Testbench for mp_regfile_sb: a default-parameter instance checked every
// cycle against a behavioural model plus literal expectations, and a second
// wide instance (6 read, 3 write ports, 16 x 64-bit) checked with literals.
module tb_mp_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int NW    = 2;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NW-1:0]    wrEn;
    logic [NW*AW-1:0] wrAddr;
    logic [NW*DW-1:0] wrData;
    logic [NW-1:0]    issEn;
    logic [NW*AW-1:0] issAddr;
    logic [NR*AW-1:0] rdAddr;
    logic [NR*DW-1:0] rdData;
    logic [NR-1:0]    rdBusy;
    logic [AW:0]      busyCnt;

    logic [2:0]   s2WrEn;
    logic [11:0]  s2WrAddr;
    logic [191:0] s2WrData;
    logic [2:0]   s2IssEn;
    logic [11:0]  s2IssAddr;
    logic [23:0]  s2RdAddr;
    logic [383:0] s2RdData;
    logic [5:0]   s2RdBusy;
    logic [4:0]   s2BusyCnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mp_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .iss_en(issEn), .iss_addr(issAddr),
        .rd_addr(rdAddr), .rd_data(rdData), .rd_busy(rdBusy),
        .busy_cnt(busyCnt)
    );

    mp_regfile_sb #(.DATA_W(64), .ADDR_W(4), .NUM_RD(6), .NUM_WR(3)) u_dut2 (
        .clk(clk), .rst(rst),
        .wr_en(s2WrEn), .wr_addr(s2WrAddr), .wr_data(s2WrData),
        .iss_en(s2IssEn), .iss_addr(s2IssAddr),
        .rd_addr(s2RdAddr), .rd_data(s2RdData), .rd_busy(s2RdBusy),
        .busy_cnt(s2BusyCnt)
    );

    // Behavioural model: plain arrays of register values and pending flags.
    bit [DW-1:0] mRegs [DEPTH];
    bit          mBusy [DEPTH];

    // Highest-index port writing address a this cycle, or -1.
    function automatic int lastWriter(input int a);
        for (int p = NW - 1; p >= 0; p--) begin
            if (wrEn[p] && int'(wrAddr[p*AW +: AW]) == a) return p;
        end
        return -1;
    endfunction

    function automatic bit issuedTo(input int a);
        for (int p = 0; p < NW; p++) begin
            if (issEn[p] && int'(issAddr[p*AW +: AW]) == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] expData(input int a);
        int w;
        if (a == 0) return '0;
        w = lastWriter(a);
        if (BYPASS && rst && w >= 0) return wrData[w*DW +: DW];
        return mRegs[a];
    endfunction

    function automatic logic expBusy(input int a);
        if (a == 0) return 1'b0;
        if (BYPASS && rst && lastWriter(a) >= 0) return issuedTo(a);
        return mBusy[a];
    endfunction

    function automatic int expCount();
        int n = 0;
        for (int a = 0; a < DEPTH; a++) n += int'(mBusy[a]);
        return n;
    endfunction

    // Model update: newest write wins, a same-cycle issue beats a clear.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                mRegs[a] = '0;
                mBusy[a] = 1'b0;
            end
        end else begin
            for (int a = 1; a < DEPTH; a++) begin
                int w;
                w = lastWriter(a);
                if (w >= 0) mRegs[a] = wrData[w*DW +: DW];
                if (issuedTo(a)) mBusy[a] = 1'b1;
                else if (w >= 0) mBusy[a] = 1'b0;
            end
        end
    end

    task automatic checkEq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Every-cycle compare of the default instance against the model.
    always @(negedge clk) begin
        for (int r = 0; r < NR; r++) begin
            int a;
            a = int'(rdAddr[r*AW +: AW]);
            checkEq($sformatf("model rd_data[%0d]", r), 64'(rdData[r*DW +: DW]), 64'(expData(a)));
            checkEq($sformatf("model rd_busy[%0d]", r), 64'(rdBusy[r]), 64'(expBusy(a)));
        end
        checkEq("model busy_cnt", 64'(busyCnt), 64'(expCount()));
    end

    task automatic applyStimulus(input logic [1:0] we, input logic [4:0] wa1, input logic [4:0] wa0,
                                 input logic [31:0] wd1, input logic [31:0] wd0,
                                 input logic [1:0] ie, input logic [4:0] ia1, input logic [4:0] ia0);
        wrEn    = we;
        wrAddr  = {wa1, wa0};
        wrData  = {wd1, wd0};
        issEn   = ie;
        issAddr = {ia1, ia0};
        #1;
    endtask

    task automatic idle();
        applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0);
    endtask

    task automatic setReads(input logic [4:0] r3, input logic [4:0] r2,
                            input logic [4:0] r1, input logic [4:0] r0);
        rdAddr = {r3, r2, r1, r0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int port,
                               input logic [31:0] expD, input logic expB);
        checkEq({name, " data"}, 64'(rdData[port*DW +: DW]), 64'(expD));
        checkEq({name, " busy"}, 64'(rdBusy[port]), 64'(expB));
    endtask

    initial begin
        wrEn = '0; wrAddr = '0; wrData = '0; issEn = '0; issAddr = '0; rdAddr = '0;
        s2WrEn = '0; s2WrAddr = '0; s2WrData = '0; s2IssEn = '0; s2IssAddr = '0; s2RdAddr = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        setReads(5'd3, 5'd2, 5'd1, 5'd0);
        #1;
        checkEq("reset busy_cnt", 64'(busyCnt), 64'd0);
        checkOutput("reset R1", 1, 32'h0, 1'b0);
        rst = 1'b1;

        // Two-port write conflict on R7: port 1 is younger and wins.
        setReads(5'd0, 5'd0, 5'd0, 5'd7);
        applyStimulus(2'b11, 5'd7, 5'd7, 32'h22, 32'h11, 2'b00, 5'd0, 5'd0);
        checkOutput("conflict same cycle R7", 0, BYPASS ? 32'h22 : 32'h0, 1'b0);
        step(); idle();
        checkOutput("conflict R7", 0, 32'h22, 1'b0);

        // Different addresses both commit.
        setReads(5'd0, 5'd0, 5'd2, 5'd1);
        applyStimulus(2'b11, 5'd2, 5'd1, 32'h200, 32'h100, 2'b00, 5'd0, 5'd0);
        step(); idle();
        checkOutput("dual write R1", 0, 32'h100, 1'b0);
        checkOutput("dual write R2", 1, 32'h200, 1'b0);

        // Register 0 ignores writes and issues.
        setReads(5'd0, 5'd0, 5'd0, 5'd0);
        applyStimulus(2'b01, 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF, 2'b01, 5'd0, 5'd0);
        checkOutput("R0 same cycle", 0, 32'h0, 1'b0);
        step(); idle();
        checkOutput("R0 after", 0, 32'h0, 1'b0);
        checkEq("R0 busy_cnt", 64'(busyCnt), 64'd0);

        // Scoreboard sequence on R3 and R9.
        setReads(5'd0, 5'd0, 5'd9, 5'd3);
        applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd9, 5'd3);
        step(); idle();
        checkEq("issue R3 R9 busy_cnt", 64'(busyCnt), 64'd2);
        checkOutput("issued R3", 0, 32'h0, 1'b1);
        checkOutput("issued R9", 1, 32'h0, 1'b1);
        applyStimulus(2'b01, 5'd0, 5'd3, 32'h0, 32'h33, 2'b10, 5'd3, 5'd0);
        checkOutput("write+issue R3 same cycle", 0, BYPASS ? 32'h33 : 32'h0, 1'b1);
        step(); idle();
        checkEq("write+issue R3 busy_cnt", 64'(busyCnt), 64'd2);
        checkOutput("write+issue R3", 0, 32'h33, 1'b1);
        applyStimulus(2'b10, 5'd9, 5'd0, 32'h99, 32'h0, 2'b00, 5'd0, 5'd0);
        checkOutput("write R9 same cycle", 1, BYPASS ? 32'h99 : 32'h0, BYPASS ? 1'b0 : 1'b1);
        step(); idle();
        checkEq("write R9 busy_cnt", 64'(busyCnt), 64'd1);
        checkOutput("write R9", 1, 32'h99, 1'b0);

        // Forwarding behaviour on R4.
        setReads(5'd0, 5'd0, 5'd0, 5'd4);
        applyStimulus(2'b01, 5'd0, 5'd4, 32'h0, 32'h1234, 2'b00, 5'd0, 5'd0);
        step(); idle();
        checkOutput("R4 old", 0, 32'h1234, 1'b0);
        applyStimulus(2'b01, 5'd0, 5'd4, 32'h0, 32'hABCD, 2'b00, 5'd0, 5'd0);
        checkOutput("R4 same cycle", 0, BYPASS ? 32'hABCD : 32'h1234, 1'b0);
        step(); idle();
        checkOutput("R4 next cycle", 0, 32'hABCD, 1'b0);
        applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b01, 5'd0, 5'd4);
        step(); idle();
        checkOutput("R4 issued", 0, 32'hABCD, 1'b1);
        checkEq("R4 issued busy_cnt", 64'(busyCnt), 64'd2);
        applyStimulus(2'b10, 5'd4, 5'd0, 32'h4444, 32'h0, 2'b00, 5'd0, 5'd0);
        checkOutput("R4 clear same cycle", 0, BYPASS ? 32'h4444 : 32'hABCD, BYPASS ? 1'b0 : 1'b1);
        step(); idle();
        checkOutput("R4 cleared", 0, 32'h4444, 1'b0);
        checkEq("R4 cleared busy_cnt", 64'(busyCnt), 64'd1);

        // Reset mid-cycle with R5 written and a write+issue in flight.
        setReads(5'd0, 5'd6, 5'd3, 5'd5);
        applyStimulus(2'b01, 5'd0, 5'd5, 32'h0, 32'hDEAD, 2'b00, 5'd0, 5'd0);
        step(); idle();
        checkOutput("R5 before reset", 0, 32'hDEAD, 1'b0);
        applyStimulus(2'b01, 5'd0, 5'd6, 32'h0, 32'h6666, 2'b01, 5'd0, 5'd6);
        rst = 1'b0;
        #1;
        checkOutput("reset R5", 0, 32'h0, 1'b0);
        checkOutput("reset R3", 1, 32'h0, 1'b0);
        checkOutput("reset R6 in flight", 2, 32'h0, 1'b0);
        checkEq("reset busy_cnt now", 64'(busyCnt), 64'd0);
        step(); step();
        checkOutput("held reset R6", 2, 32'h0, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        checkOutput("after reset R5", 0, 32'h0, 1'b0);
        checkEq("after reset busy_cnt", 64'(busyCnt), 64'd0);

        // Mixed traffic on a small address window to force collisions.
        for (int i = 0; i < 40; i++) begin
            setReads(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            applyStimulus(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          $urandom, $urandom,
                          2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end
        idle();
        step();

        // Wide instance: three-port conflict, register 0, scoreboard.
        s2RdAddr = {4'd9, 4'd0, 4'd0, 4'd0, 4'd3, 4'd7};
        s2WrEn   = 3'b111;
        s2WrAddr = {4'd7, 4'd7, 4'd7};
        s2WrData = {64'h3333_0000_0000_0033, 64'h2222_0000_0000_0022, 64'h1111_0000_0000_0011};
        step();
        s2WrEn = '0;
        #1;
        checkEq("sweep conflict R7", s2RdData[63:0], 64'h3333_0000_0000_0033);
        s2WrEn    = 3'b010;
        s2WrAddr  = {4'd0, 4'd0, 4'd0};
        s2WrData  = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        s2IssEn   = 3'b100;
        s2IssAddr = {4'd0, 4'd0, 4'd0};
        s2RdAddr  = {4'd9, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0};
        step();
        s2WrEn = '0; s2IssEn = '0;
        #1;
        checkEq("sweep R0 data", s2RdData[63:0], 64'h0);
        checkEq("sweep R0 busy", 64'(s2RdBusy[0]), 64'd0);
        checkEq("sweep R0 busy_cnt", 64'(s2BusyCnt), 64'd0);
        s2IssEn   = 3'b011;
        s2IssAddr = {4'd0, 4'd9, 4'd3};
        step();
        s2IssEn = '0;
        #1;
        checkEq("sweep issue busy_cnt", 64'(s2BusyCnt), 64'd2);
        s2WrEn    = 3'b001;
        s2WrAddr  = {4'd0, 4'd0, 4'd3};
        s2WrData  = {64'h0, 64'h0, 64'h0000_0000_0000_0333};
        s2IssEn   = 3'b100;
        s2IssAddr = {4'd3, 4'd0, 4'd0};
        step();
        s2WrEn = '0; s2IssEn = '0;
        #1;
        checkEq("sweep write+issue busy_cnt", 64'(s2BusyCnt), 64'd2);
        checkEq("sweep R3 busy", 64'(s2RdBusy[1]), 64'd1);
        checkEq("sweep R3 data", s2RdData[127:64], 64'h0000_0000_0000_0333);
        s2WrEn   = 3'b100;
        s2WrAddr = {4'd9, 4'd0, 4'd0};
        s2WrData = {64'h0000_0000_0000_0999, 64'h0, 64'h0};
        step();
        s2WrEn = '0;
        #1;
        checkEq("sweep write R9 busy_cnt", 64'(s2BusyCnt), 64'd1);
        checkEq("sweep R9 busy", 64'(s2RdBusy[5]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
